// File: rtl/vfpu_norm_round.sv
// ---------------------------------------------------------------------------
// vfpu_norm_round
//
// Normalizes an unnormalized 48-bit mantissa product, rounds it to nearest
// even and packs it into an IEEE-754 single-precision word. Two pipeline
// stages with valid/ready handshaking on both sides:
//   S1 : shift the leading one up to bit 47 and rebase the exponent.
//   S2 : round on guard/sticky, handle rounding carry, range-check, pack.
//
// Ports
//   clk_i            clock, rising edge
//   rst_ni           synchronous active-low reset
//   in_valid_i       operand valid
//   in_ready_o       block accepts an operand this cycle
//   mant_i           unnormalized mantissa product (WIDTH bits)
//   exp_i            signed biased exponent, referenced to a leading one at bit 46
//   sign_i           result sign
//   lod_first_one_i  position of the most significant 1 in mant_i
//   lod_no_ones_i    mant_i is all zeros
//   out_valid_o      result valid
//   out_ready_i      downstream accepts the result
//   result_o         packed single-precision result
//   overflow_o       result saturated to infinity
//   underflow_o      result flushed to zero
// ---------------------------------------------------------------------------
module vfpu_norm_round #(
  parameter int WIDTH = 48,
  parameter int EXP_W = 10
) (
  input  logic                    clk_i,
  input  logic                    rst_ni,
  input  logic                    in_valid_i,
  output logic                    in_ready_o,
  input  logic [WIDTH-1:0]        mant_i,
  input  logic signed [EXP_W-1:0] exp_i,
  input  logic                    sign_i,
  input  logic [5:0]              lod_first_one_i,
  input  logic                    lod_no_ones_i,
  output logic                    out_valid_o,
  input  logic                    out_ready_i,
  output logic [31:0]             result_o,
  output logic                    overflow_o,
  output logic                    underflow_o
);

  // One extra bit so exp_i + first_one - 46 (+1 on rounding carry) never wraps.
  localparam int EW = EXP_W + 1;

  localparam logic signed [EW-1:0] EXP_ZERO = '0;
  localparam logic signed [EW-1:0] EXP_ONE  = EW'(1);
  localparam logic signed [EW-1:0] EXP_MAX  = EW'(255);
  localparam logic signed [EW-1:0] EXP_REF  = EW'(46);

  // Stage 1 registers
  logic                 s1_valid;
  logic [WIDTH-1:0]     s1_norm;
  logic signed [EW-1:0] s1_exp;
  logic                 s1_sign;
  logic                 s1_zero;

  // Handshake
  logic s1_adv;

  // Stage 1 combinational
  logic [5:0]           shift_d;
  logic [WIDTH-1:0]     norm_d;
  logic signed [EW-1:0] exp_ext;
  logic signed [EW-1:0] first_ext;
  logic signed [EW-1:0] exp_d;

  // Stage 2 combinational
  logic [23:0]          sig;
  logic                 guard;
  logic                 sticky;
  logic                 round_up;
  logic [24:0]          sig_inc;
  logic [23:0]          sig_fin;
  logic signed [EW-1:0] exp_fin;
  logic [31:0]          result_d;
  logic                 overflow_d;
  logic                 underflow_d;

  // S2 can take a new value when it is empty or its result is leaving;
  // S1 can take a new operand when it is empty or moving into S2.
  assign s1_adv     = !out_valid_o | out_ready_i;
  assign in_ready_o = !s1_valid | s1_adv;

  // Normalize so the leading one sits at bit 47 and rebase the exponent.
  // A first_one above 47 is a don't-care, so the 6-bit wrap is harmless.
  always_comb begin
    shift_d   = 6'd47 - lod_first_one_i;
    norm_d    = mant_i << shift_d;
    exp_ext   = {exp_i[EXP_W-1], exp_i};
    first_ext = {{(EW-6){1'b0}}, lod_first_one_i};
    exp_d     = exp_ext + first_ext - EXP_REF;
  end

  // Round to nearest even, fold any carry back into the exponent, then
  // classify into zero / overflow / underflow / normal.
  always_comb begin
    sig         = s1_norm[47:24];
    guard       = s1_norm[23];
    sticky      = |s1_norm[22:0];
    round_up    = guard & (sticky | s1_norm[24]);
    sig_inc     = {1'b0, sig} + {24'b0, round_up};
    sig_fin     = sig_inc[23:0];
    exp_fin     = s1_exp;
    result_d    = {s1_sign, 31'b0};
    overflow_d  = 1'b0;
    underflow_d = 1'b0;

    if (sig_inc[24]) begin
      sig_fin = 24'h800000;
      exp_fin = s1_exp + EXP_ONE;
    end

    if (s1_zero) begin
      result_d = {s1_sign, 31'b0};
    end else if (exp_fin >= EXP_MAX) begin
      result_d   = {s1_sign, 8'hFF, 23'b0};
      overflow_d = 1'b1;
    end else if (exp_fin <= EXP_ZERO) begin
      result_d    = {s1_sign, 31'b0};
      underflow_d = 1'b1;
    end else begin
      result_d = {s1_sign, exp_fin[7:0], sig_fin[22:0]};
    end
  end

  // Stage valid bits and the output register. Outputs only change when S2
  // advances, so they hold steady while downstream stalls.
  always_ff @(posedge clk_i) begin
    if (!rst_ni) begin
      s1_valid    <= 1'b0;
      out_valid_o <= 1'b0;
      result_o    <= 32'b0;
      overflow_o  <= 1'b0;
      underflow_o <= 1'b0;
    end else begin
      if (in_ready_o) begin
        s1_valid <= in_valid_i;
      end
      if (s1_adv) begin
        out_valid_o <= s1_valid;
        if (s1_valid) begin
          result_o    <= result_d;
          overflow_o  <= overflow_d;
          underflow_o <= underflow_d;
        end
      end
    end
  end

  // S1 payload; qualified by s1_valid, so it needs no reset.
  always_ff @(posedge clk_i) begin
    if (in_ready_o && in_valid_i) begin
      s1_norm <= norm_d;
      s1_exp  <= exp_d;
      s1_sign <= sign_i;
      s1_zero <= lod_no_ones_i;
    end
  end

endmodule
